// File: rtl/mode_counter_pkg.sv
// Shared defaults and boundary-mode encodings for the mode_counter block.
// Also holds the prescaler width helper so top and sub-module agree on sizing.
package mode_counter_pkg;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_MAX_AMOUNT = 69;
  localparam int DEFAULT_PRESCALE   = 1;

  // SATURATE encodings: wrap around at the limits, or hold at them
  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/mode_counter_prescaler.sv
// Enabled-cycle divider: tick is combinational, high on the enabled cycle ending each
// PRESCALE-long group. No backpressure; restart zeroes the phase and outranks enable.
module mode_counter_prescaler
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      phase <= '0;
    end else if (enable) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down bounded counter with prescaler, load, wrap/saturate mode and boundary flags.
// count updates on the edge ending a qualifying cycle (1-cycle latency); no backpressure.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MAX_AMOUNT = DEFAULT_MAX_AMOUNT,
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int SATURATE   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             overflow_sticky
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_AMOUNT);
  localparam bit               HOLD  = (SATURATE == SAT_HOLD);

  generate
    if (!(MAX_AMOUNT >= 1 && longint'(MAX_AMOUNT) < (longint'(1) << WIDTH) &&
          PRESCALE >= 1 && (SATURATE == SAT_WRAP || SATURATE == SAT_HOLD))) begin : g_bad_params
      $error("mode_counter: illegal WIDTH/MAX_AMOUNT/PRESCALE/SATURATE combination");
    end
  endgenerate

  logic             tick;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] count_nxt;

  // load restarts the prescaler so a fresh value always gets a full PRESCALE period
  mode_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (load),
    .tick    (tick)
  );

  always_comb begin
    step      = tick && !load;
    boundary  = step && (up ? (count == MAX_W) : (count == '0));
    count_nxt = count;
    if (load) begin
      count_nxt = (load_value > MAX_W) ? MAX_W : load_value;
    end else if (step) begin
      if (up) begin
        count_nxt = (count == MAX_W) ? (HOLD ? count : '0) : count + WIDTH'(1);
      end else begin
        count_nxt = (count == '0) ? (HOLD ? count : MAX_W) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= '0;
      wrap_pulse      <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= boundary;
      // a new event beats a simultaneous clear
      if (boundary) begin
        overflow_sticky <= 1'b1;
      end else if (clear_flag) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

  assign at_max  = (count == MAX_W);
  assign at_zero = (count == '0);

  a_count_range: assert property (@(posedge clk) count <= MAX_W);
  a_wrap_cause:  assert property (@(posedge clk) disable iff (reset) wrap_pulse |-> $past(boundary));

endmodule
